// File: rtl/mp_pkg.sv
// Shared bus-side definitions for the memory responder: state encoding and default widths.
package mp_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH x DATA_W storage with synchronous write and a registered, clearable read port.
module mem_array #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 200,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rd_clr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Contents are never reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_clr)     rdata_d = '0;
    else if (rd_en) rdata_d = mem_q[idx];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Request/response memory slave: accepts one access at a time, inserts WAIT_CYC wait states,
// then holds the response until the initiator acknowledges it.
module mem_responder
  import mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DEPTH    = 200,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              req_rdy,
  output logic              rsp_vld,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  input  logic              rsp_ack
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  logic [1:0]        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              we_d, we_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic              err_d, err_q;
  logic              req_rdy_d, req_rdy_q;
  logic              rsp_vld_d, rsp_vld_q;
  logic              in_range;
  logic              mem_wr_en, mem_rd_en, mem_rd_clr;

  // Extra bit keeps the compare correct when DEPTH == 2**ADDR_W.
  assign in_range = ({1'b0, addr_q} < (ADDR_W+1)'(DEPTH));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    mem_wr_en  = 1'b0;
    mem_rd_en  = 1'b0;
    mem_rd_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          if (WAIT_CYC == 0) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYC - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_ACCESS: begin
        state_d    = ST_RESP;
        err_d      = !in_range;
        mem_wr_en  = we_q && in_range;
        mem_rd_en  = !we_q && in_range;
        mem_rd_clr = we_q || !in_range;
      end
      ST_RESP: begin
        if (rsp_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Reset wins: an ACCESS cycle hit by reset must not commit its write.
    if (reset) begin
      mem_wr_en  = 1'b0;
      mem_rd_en  = 1'b0;
      mem_rd_clr = 1'b1;
    end
    req_rdy_d = (state_d == ST_IDLE);
    rsp_vld_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      req_rdy_q <= 1'b1;
      rsp_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      req_rdy_q <= req_rdy_d;
      rsp_vld_q <= rsp_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk    (clk),
    .rd_clr (mem_rd_clr),
    .rd_en  (mem_rd_en),
    .wr_en  (mem_wr_en),
    .idx    (addr_q[IDX_W-1:0]),
    .wdata  (wdata_q),
    .rdata  (rdata)
  );

  assign req_rdy = req_rdy_q;
  assign rsp_vld = rsp_vld_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: default instance (WAIT_CYC=2) and a zero-wait instance.
module tb_mem_responder;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam int          W0    = 2;
  localparam int          W1    = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          sel, rst0, rst1, req_r, we_r, ack_r, ack_tie;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic          rdy0, vld0, err0, rdy1, vld1, err1;
  logic [DW-1:0] rd0, rd1;
  logic          req0, req1, ack0, ack1;
  logic          rdy_m, vld_m, err_m;
  logic [DW-1:0] rd_m;

  assign req0  = req_r & ~sel;
  assign req1  = req_r & sel;
  assign ack0  = (ack_r | ack_tie) & ~sel;
  assign ack1  = (ack_r | ack_tie) & sel;
  assign rdy_m = sel ? rdy1 : rdy0;
  assign vld_m = sel ? vld1 : vld0;
  assign err_m = sel ? err1 : err0;
  assign rd_m  = sel ? rd1  : rd0;

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(W0)) u_dut0 (
    .clk(clk), .reset(rst0), .req(req0), .we(we_r), .addr(addr_r), .wdata(wdata_r),
    .req_rdy(rdy0), .rsp_vld(vld0), .rdata(rd0), .err(err0), .rsp_ack(ack0)
  );

  mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(W1)) u_dut1 (
    .clk(clk), .reset(rst1), .req(req1), .we(we_r), .addr(addr_r), .wdata(wdata_r),
    .req_rdy(rdy1), .rsp_vld(vld1), .rdata(rd1), .err(err1), .rsp_ack(ack1)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  logic [DW-1:0] mdl [2][256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request; returns the cycle count at the accepting edge.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit abort, output int t_acc);
    int   n = 0;
    exp_t e;
    while (!rdy_m && n < 40) begin step(); n++; end
    if (!rdy_m) check("rdy_wait", 32'(rdy_m), 32'd1);
    req_r = 1'b1; we_r = w; addr_r = a; wdata_r = d;
    if (!abort) begin
      e.err   = (32'(a) >= DEPTH);
      e.rdata = (w || e.err) ? '0 : mdl[sel][a];
      e.lat   = (sel ? W1 : W0) + 2;
      if (w && !e.err) mdl[sel][a] = d;
      exp_q.push_back(e);
    end
    step();
    t_acc = cyc;
    req_r = 1'b0;
  endtask

  // Wait for the response, compare against the scoreboard, hold it, then acknowledge.
  task automatic collect(input int hold, input bit poke);
    int   lat = 1;
    exp_t e;
    while (!vld_m && lat < 40) begin step(); lat++; end
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("rdata", 32'(rd_m), 32'(e.rdata));
    check("err", 32'(err_m), 32'(e.err));
    for (int i = 1; i < hold; i++) begin
      if (poke) begin req_r = 1'b1; we_r = 1'b1; addr_r = 8'h10; wdata_r = 8'hEE; end
      step();
      check("hold_vld", 32'(vld_m), 32'd1);
      check("hold_rdata", 32'(rd_m), 32'(e.rdata));
      check("hold_err", 32'(err_m), 32'(e.err));
      check("hold_rdy", 32'(rdy_m), 32'd0);
    end
    req_r = 1'b0;
    if (!ack_tie) begin
      ack_r = 1'b1; step(); ack_r = 1'b0;
    end else begin
      step();
    end
    check("post_vld", 32'(vld_m), 32'd0);
    check("post_rdy", 32'(rdy_m), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tprev;
    sel = 1'b0; rst0 = 1'b1; rst1 = 1'b1; req_r = 1'b0; we_r = 1'b0; ack_r = 1'b0;
    ack_tie = 1'b0; addr_r = '0; wdata_r = '0; t = 0; tprev = 0;
    repeat (3) step();
    check("rst_rdy", 32'(rdy0), 32'd1);
    check("rst_vld", 32'(vld0), 32'd0);
    check("rst_rdata", 32'(rd0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    rst0 = 1'b0; rst1 = 1'b0;
    step();

    // Write then read, then a read held under backpressure with a stray request.
    issue(1'b1, 8'h10, 8'hA5, 1'b0, t); collect(1, 1'b0);
    issue(1'b0, 8'h10, 8'h00, 1'b0, t); collect(1, 1'b0);
    issue(1'b0, 8'h10, 8'h00, 1'b0, t); collect(6, 1'b1);
    issue(1'b0, 8'h10, 8'h00, 1'b0, t); collect(1, 1'b0);

    // Address range boundary.
    issue(1'b1, 8'hC8, 8'h3C, 1'b0, t); collect(1, 1'b0);
    issue(1'b0, 8'hC8, 8'h00, 1'b0, t); collect(1, 1'b0);
    issue(1'b0, 8'h10, 8'h00, 1'b0, t); collect(1, 1'b0);
    issue(1'b1, 8'hC7, 8'h5A, 1'b0, t); collect(1, 1'b0);
    issue(1'b0, 8'hC7, 8'h00, 1'b0, t); collect(1, 1'b0);
    issue(1'b1, 8'hFF, 8'h12, 1'b0, t); collect(1, 1'b0);

    // Reset during WAIT, then during ACCESS: neither write may land.
    issue(1'b1, 8'h20, 8'h11, 1'b0, t); collect(1, 1'b0);
    issue(1'b1, 8'h20, 8'h77, 1'b1, t);
    rst0 = 1'b1; step(); rst0 = 1'b0;
    check("rstw_vld", 32'(vld0), 32'd0);
    check("rstw_rdy", 32'(rdy0), 32'd1);
    check("rstw_rdata", 32'(rd0), 32'd0);
    issue(1'b0, 8'h20, 8'h00, 1'b0, t); collect(1, 1'b0);
    issue(1'b1, 8'h20, 8'h99, 1'b1, t);
    step(); step();
    rst0 = 1'b1; step(); rst0 = 1'b0;
    check("rsta_vld", 32'(vld0), 32'd0);
    check("rsta_err", 32'(err0), 32'd0);
    issue(1'b0, 8'h20, 8'h00, 1'b0, t); collect(1, 1'b0);

    // Ack tied high: back-to-back writes one IDLE cycle apart.
    ack_tie = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, AW'(i), DW'(8'h40 + i), 1'b0, t);
      if (i > 0) check("b2b_spacing", 32'(t - tprev), 32'(W0 + 3));
      tprev = t;
      collect(1, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, AW'(i), 8'h00, 1'b0, t); collect(1, 1'b0);
    end
    ack_tie = 1'b0;

    // Zero-wait instance.
    sel = 1'b1;
    step();
    check("z_rdy", 32'(rdy1), 32'd1);
    issue(1'b1, 8'h10, 8'hA5, 1'b0, t); collect(1, 1'b0);
    issue(1'b0, 8'h10, 8'h00, 1'b0, t); collect(1, 1'b0);
    issue(1'b0, 8'hC8, 8'h00, 1'b0, t); collect(1, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
